pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_if.sv | 42 ++++
 rtl/pc_sequencer.sv | 107 ++++++++++
 tb/tb_pc_sequencer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// ============================================================================
//  Module   : pc_sequencer_if
//  Purpose  : Bundles the decoded instruction requests, the asynchronous go
//             input and the sequencer status outputs into one interface.
//  Modports : master - instruction decoder / control side (drives requests)
//             slave  - pc_sequencer (drives PC and status)
//  Signals  : PCincr, PCrelbranch, PCabsbranch, Branchaddr[Psize-1:0],
//             wait_req, halt_req, go            (master -> slave)
//             PCout[Psize-1:0], waiting, halted, reg_we (slave -> master)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_sequencer_if #(
  parameter int Psize = 6
);
  logic             PCincr;
  logic             PCrelbranch;
  logic             PCabsbranch;
  logic [Psize-1:0] Branchaddr;
  logic             wait_req;
  logic             halt_req;
  logic             go;
  logic [Psize-1:0] PCout;
  logic             waiting;
  logic             halted;
  logic             reg_we;

  modport master (
    output PCincr, PCrelbranch, PCabsbranch, Branchaddr,
    output wait_req, halt_req, go,
    input  PCout, waiting, halted, reg_we
  );

  modport slave (
    input  PCincr, PCrelbranch, PCabsbranch, Branchaddr,
    input  wait_req, halt_req, go,
    output PCout, waiting, halted, reg_we
  );
endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : Program-counter sequencer with RUN / WAIT / HALT control.
//             RUN follows decoded requests (halt > wait > abs > rel > incr);
//             WAIT leaves on a synchronised rising edge of the go button;
//             HALT is absorbing until reset.
//  Ports    : clk    - system clock, rising-edge active
//             nReset - asynchronous active-low reset
//             bus    - pc_sequencer_if.slave (requests in, PC/status out)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
  parameter int Psize = 6
) (
  input  wire logic          clk,
  input  wire logic          nReset,
  pc_sequencer_if.slave      bus
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [Psize-1:0] C_ONE = Psize'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [Psize-1:0] r_pc;
  logic [Psize-1:0] w_pc_nxt;
  logic             r_go_s1;
  logic             r_go_s2;
  logic             r_go_s3;
  logic             w_go_edge;

  // go is asynchronous: two flops resolve metastability, the third holds the
  // previous synchronised value for edge detection. Runs in every state so a
  // level already high on WAIT entry never looks like a fresh edge.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_go_s1 <= 1'b0;
      r_go_s2 <= 1'b0;
      r_go_s3 <= 1'b0;
    end else begin
      r_go_s1 <= bus.go;
      r_go_s2 <= r_go_s1;
      r_go_s3 <= r_go_s2;
    end
  end

  assign w_go_edge = r_go_s2 & ~r_go_s3;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= S_RUN;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      S_RUN: begin
        if (bus.halt_req) begin
          w_state_nxt = S_HALT;
        end else if (bus.wait_req) begin
          w_state_nxt = S_WAIT;
        end else if (bus.PCabsbranch) begin
          w_pc_nxt = bus.Branchaddr;
        end else if (bus.PCrelbranch) begin
          // Sign extension followed by truncation to Psize bits is the same
          // as a plain Psize-bit two's-complement add.
          w_pc_nxt = r_pc + bus.Branchaddr;
        end else if (bus.PCincr) begin
          w_pc_nxt = r_pc + C_ONE;
        end
      end
      S_WAIT: begin
        if (w_go_edge) begin
          w_pc_nxt    = r_pc + C_ONE;
          w_state_nxt = S_RUN;
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  assign bus.PCout   = r_pc;
  assign bus.waiting = (r_state == S_WAIT);
  assign bus.halted  = (r_state == S_HALT);
  assign bus.reg_we  = (r_state == S_RUN) & ~bus.wait_req & ~bus.halt_req;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
//  Module   : tb_pc_sequencer
//  Purpose  : Directed self-checking bench for pc_sequencer (Psize = 6).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  logic clk;
  logic nReset;
  int   n_tests;
  int   n_fail;

  pc_sequencer_if #(.Psize(6)) bus ();

  pc_sequencer #(.Psize(6)) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.PCincr      = 1'b0;
    bus.PCrelbranch = 1'b0;
    bus.PCabsbranch = 1'b0;
    bus.Branchaddr  = '0;
    bus.wait_req    = 1'b0;
    bus.halt_req    = 1'b0;
  endtask

  task automatic jump_to(input logic [5:0] target);
    clear_inputs();
    bus.PCabsbranch = 1'b1;
    bus.Branchaddr  = target;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.go = 1'b0;
    nReset = 1'b0;
    #3;
    n_tests++;
    if (bus.PCout !== 6'd0 || bus.waiting !== 1'b0 || bus.halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: PCout=%0d waiting=%b halted=%b, want 0/0/0",
               bus.PCout, bus.waiting, bus.halted);
    end
    tick();
    tick();
    n_tests++;
    if (bus.PCout !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_held: PCout=%0d, want 0", bus.PCout);
    end
    #3;
    nReset = 1'b1;
  endtask

  task automatic test_incr_wrap();
    bus.PCincr = 1'b1;
    n_tests++;
    if (bus.reg_we !== 1'b1) begin
      n_fail++;
      $display("FAIL incr_reg_we: reg_we=%b, want 1", bus.reg_we);
    end
    for (int i = 1; i <= 65; i++) begin
      tick();
      n_tests++;
      if (bus.PCout !== 6'(i % 64)) begin
        n_fail++;
        $display("FAIL incr_step%0d: PCout=%0d, want %0d", i, bus.PCout, i % 64);
      end
    end
    // Advance 1 -> 10, then confirm hold with no request.
    for (int i = 0; i < 9; i++) tick();
    clear_inputs();
    tick();
    tick();
    n_tests++;
    if (bus.PCout !== 6'd10) begin
      n_fail++;
      $display("FAIL idle_hold: PCout=%0d, want 10", bus.PCout);
    end
  endtask

  task automatic test_branch();
    bus.PCrelbranch = 1'b1;
    bus.Branchaddr  = 6'b111101;
    tick();
    n_tests++;
    if (bus.PCout !== 6'd7) begin
      n_fail++;
      $display("FAIL rel_minus3: PCout=%0d, want 7", bus.PCout);
    end
    clear_inputs();
    bus.PCabsbranch = 1'b1;
    bus.PCincr      = 1'b1;
    bus.Branchaddr  = 6'd40;
    tick();
    n_tests++;
    if (bus.PCout !== 6'd40) begin
      n_fail++;
      $display("FAIL abs_over_incr: PCout=%0d, want 40", bus.PCout);
    end
    clear_inputs();
    bus.PCrelbranch = 1'b1;
    bus.PCincr      = 1'b1;
    bus.Branchaddr  = 6'd5;
    tick();
    n_tests++;
    if (bus.PCout !== 6'd45) begin
      n_fail++;
      $display("FAIL rel_plus5: PCout=%0d, want 45", bus.PCout);
    end
    bus.Branchaddr = 6'd30;
    tick();
    n_tests++;
    if (bus.PCout !== 6'd11) begin
      n_fail++;
      $display("FAIL rel_wrap: PCout=%0d, want 11", bus.PCout);
    end
    bus.PCabsbranch = 1'b1;
    bus.Branchaddr  = 6'd3;
    tick();
    n_tests++;
    if (bus.PCout !== 6'd3) begin
      n_fail++;
      $display("FAIL abs_over_rel: PCout=%0d, want 3", bus.PCout);
    end
    clear_inputs();
  endtask

  task automatic test_wait_go();
    jump_to(6'd5);
    bus.wait_req = 1'b1;
    #1;
    n_tests++;
    if (bus.reg_we !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_req_reg_we: reg_we=%b, want 0", bus.reg_we);
    end
    tick();
    bus.wait_req = 1'b0;
    #1;
    n_tests++;
    if (bus.waiting !== 1'b1 || bus.reg_we !== 1'b0 || bus.PCout !== 6'd5) begin
      n_fail++;
      $display("FAIL wait_entry: waiting=%b reg_we=%b PCout=%0d, want 1/0/5",
               bus.waiting, bus.reg_we, bus.PCout);
    end
    // Requests must be ignored while waiting.
    bus.PCincr      = 1'b1;
    bus.PCabsbranch = 1'b1;
    bus.Branchaddr  = 6'd50;
    for (int i = 0; i < 20; i++) tick();
    n_tests++;
    if (bus.PCout !== 6'd5 || bus.waiting !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_hold20: PCout=%0d waiting=%b, want 5/1", bus.PCout, bus.waiting);
    end
    clear_inputs();
    bus.go = 1'b1;
    tick();  // edge k: first sample of go
    tick();  // edge k+1
    n_tests++;
    if (bus.PCout !== 6'd5 || bus.waiting !== 1'b1) begin
      n_fail++;
      $display("FAIL go_latency_k1: PCout=%0d waiting=%b, want 5/1", bus.PCout, bus.waiting);
    end
    tick();  // edge k+2
    n_tests++;
    if (bus.PCout !== 6'd6 || bus.waiting !== 1'b0) begin
      n_fail++;
      $display("FAIL go_exit_k2: PCout=%0d waiting=%b, want 6/0", bus.PCout, bus.waiting);
    end
  endtask

  task automatic test_go_level_high();
    // go is still high from the previous scenario.
    bus.wait_req = 1'b1;
    tick();
    bus.wait_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    n_tests++;
    if (bus.PCout !== 6'd6 || bus.waiting !== 1'b1) begin
      n_fail++;
      $display("FAIL go_level_no_exit: PCout=%0d waiting=%b, want 6/1", bus.PCout, bus.waiting);
    end
    bus.go = 1'b0;
    tick();
    tick();
    tick();
    bus.go = 1'b1;
    tick();
    tick();
    n_tests++;
    if (bus.PCout !== 6'd6 || bus.waiting !== 1'b1) begin
      n_fail++;
      $display("FAIL repulse_early: PCout=%0d waiting=%b, want 6/1", bus.PCout, bus.waiting);
    end
    tick();
    n_tests++;
    if (bus.PCout !== 6'd7 || bus.waiting !== 1'b0) begin
      n_fail++;
      $display("FAIL repulse_exit: PCout=%0d waiting=%b, want 7/0", bus.PCout, bus.waiting);
    end
  endtask

  task automatic test_halt();
    bus.go = 1'b0;
    jump_to(6'd12);
    bus.halt_req = 1'b1;
    bus.wait_req = 1'b1;
    #1;
    n_tests++;
    if (bus.reg_we !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_req_reg_we: reg_we=%b, want 0", bus.reg_we);
    end
    tick();
    clear_inputs();
    #1;
    n_tests++;
    if (bus.halted !== 1'b1 || bus.waiting !== 1'b0 || bus.PCout !== 6'd12) begin
      n_fail++;
      $display("FAIL halt_entry: halted=%b waiting=%b PCout=%0d, want 1/0/12",
               bus.halted, bus.waiting, bus.PCout);
    end
    bus.PCincr = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.go       = ~bus.go;
      bus.wait_req = i[0];
      tick();
    end
    n_tests++;
    if (bus.halted !== 1'b1 || bus.PCout !== 6'd12 || bus.reg_we !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_absorb: halted=%b PCout=%0d reg_we=%b, want 1/12/0",
               bus.halted, bus.PCout, bus.reg_we);
    end
  endtask

  task automatic test_async_reset();
    #2;  // mid-cycle, well away from any edge
    nReset = 1'b0;
    #1;
    n_tests++;
    if (bus.PCout !== 6'd0 || bus.halted !== 1'b0 || bus.waiting !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: PCout=%0d halted=%b waiting=%b, want 0/0/0",
               bus.PCout, bus.halted, bus.waiting);
    end
    #1;
    nReset = 1'b1;
    clear_inputs();
    bus.go     = 1'b0;
    bus.PCincr = 1'b1;
    tick();
    n_tests++;
    if (bus.PCout !== 6'd1 || bus.halted !== 1'b0) begin
      n_fail++;
      $display("FAIL resume_run: PCout=%0d halted=%b, want 1/0", bus.PCout, bus.halted);
    end
    clear_inputs();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_incr_wrap();
    test_branch();
    test_wait_go();
    test_go_level_high();
    test_halt();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
